// File: rtl/ring_shift_ctrl.sv
// ring_shift_ctrl: command-driven sequencer for an SR_W-bit ring shift register.
// Accepts LOAD / ROTATE / SHIFT_IN / NOP commands over a valid/ready handshake,
// steps the ring once per SHIFT cycle, and pulses done_o for one cycle at the end.
// Optional feature macro RING_SHIFT_CTRL_DIR_EN adds cmd_dir_i (1 = shift right).
module ring_shift_ctrl #(
    parameter int              SR_W          = 8,
    parameter int              CNT_W         = 4,
    parameter logic [SR_W-1:0] RESET_PATTERN = 8'hAA
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [SR_W-1:0]  cmd_data_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
`ifdef RING_SHIFT_CTRL_DIR_EN
    input  logic             cmd_dir_i,
`endif
    input  logic             abort_i,
    output logic [SR_W-1:0]  ring_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_LOAD     = 2'd1,
        OP_ROTATE   = 2'd2,
        OP_SHIFT_IN = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Command fields captured at accept; src is consumed LSB-first by SHIFT_IN.
    typedef struct packed {
        logic            shift_in;
        logic            dir;
        logic [SR_W-1:0] src;
    } cmd_lat_t;

    state_e           state_q, state_d;
    cmd_lat_t         cmd_q;
    logic [SR_W-1:0]  ring_q, ring_next;
    logic [CNT_W-1:0] remaining_q;
    logic             accept, step, dir_in, in_bit;

`ifdef RING_SHIFT_CTRL_DIR_EN
    assign dir_in = cmd_dir_i;
`else
    assign dir_in = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        step        = 1'b0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept = 1'b1;
                    unique case (op_e'(cmd_op_i))
                        OP_LOAD:                state_d = ST_DONE;
                        OP_ROTATE, OP_SHIFT_IN: state_d = (cmd_cnt_i == '0) ? ST_DONE : ST_SHIFT;
                        default:                state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SHIFT: begin
                busy_o = 1'b1;
                // Abort wins over the pending step, including the final one.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One ring step: rotate feeds back the outgoing bit, shift-in takes the next source bit.
    always_comb begin
        in_bit    = cmd_q.shift_in ? cmd_q.src[0]
                  : (cmd_q.dir ? ring_q[0] : ring_q[SR_W-1]);
        ring_next = cmd_q.dir ? {in_bit, ring_q[SR_W-1:1]}
                              : {ring_q[SR_W-2:0], in_bit};
    end

    // Ring, step counter and latched command.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ring_q      <= RESET_PATTERN;
            remaining_q <= '0;
            cmd_q       <= '0;
        end else if (accept) begin
            if (op_e'(cmd_op_i) == OP_LOAD) ring_q <= cmd_data_i;
            remaining_q    <= cmd_cnt_i;
            cmd_q.shift_in <= (op_e'(cmd_op_i) == OP_SHIFT_IN);
            cmd_q.dir      <= dir_in;
            cmd_q.src      <= cmd_data_i;
        end else if (step) begin
            ring_q      <= ring_next;
            remaining_q <= remaining_q - 1'b1;
            // Zero-fill so steps beyond SR_W insert 0.
            cmd_q.src   <= cmd_q.src >> 1;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: tb/tb_ring_shift_ctrl.sv
// Self-checking bench for ring_shift_ctrl: directed cases with literal expectations,
// then randomized commands/aborts checked every cycle against a behavioural model.
module tb_ring_shift_ctrl;
    localparam int SR_W  = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid, ready, abort, busy, done, dir;
    logic [1:0]       op;
    logic [SR_W-1:0]  data, ring;
    logic [CNT_W-1:0] cnt;

    int errors = 0;
    int checks = 0;

    ring_shift_ctrl #(.SR_W(SR_W), .CNT_W(CNT_W), .RESET_PATTERN(8'hAA)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .cmd_valid_i (valid),
        .cmd_ready_o (ready),
        .cmd_op_i    (op),
        .cmd_data_i  (data),
        .cmd_cnt_i   (cnt),
`ifdef RING_SHIFT_CTRL_DIR_EN
        .cmd_dir_i   (dir),
`endif
        .abort_i     (abort),
        .ring_o      (ring),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ring value after t steps of op from r0, computed directly from the step count.
    function automatic logic [7:0] model_ring(input int o, input bit d_right,
                                              input logic [7:0] r0, input logic [7:0] src, input int t);
        logic [15:0] w;
        logic [7:0]  r;
        int          idx;
        r = '0;
        if (o == 2) begin
            w = {r0, r0};
            if (!d_right) begin w = w << (t % 8); r = w[15:8]; end
            else          begin w = w >> (t % 8); r = w[7:0];  end
        end else begin
            for (int j = 0; j < 8; j++) begin
                // j counts positions from the insertion end
                if (j < t) begin
                    idx = t - 1 - j;
                    if (!d_right) r[j]     = (idx < 8) ? src[idx] : 1'b0;
                    else          r[7 - j] = (idx < 8) ? src[idx] : 1'b0;
                end else begin
                    if (!d_right) r[j]     = r0[j - t];
                    else          r[7 - j] = r0[7 - j + t];
                end
            end
        end
        return r;
    endfunction

    // Behavioural model: one command in flight, progress measured in steps taken.
    logic [7:0] m_ring, m_r0, m_src;
    bit         m_active, m_done, m_dir, dir_eff;
    int         m_t, m_n, m_op;

`ifdef RING_SHIFT_CTRL_DIR_EN
    assign dir_eff = dir;
`else
    assign dir_eff = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ring = 8'hAA; m_active = 0; m_done = 0; m_t = 0; m_n = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (abort) m_active = 0;
            else begin
                m_t++;
                m_ring = model_ring(m_op, m_dir, m_r0, m_src, m_t);
                if (m_t == m_n) begin m_active = 0; m_done = 1; end
            end
        end else if (valid) begin
            if (op == 2'd1) begin
                m_ring = data; m_done = 1;
            end else if (op != 2'd0) begin
                m_op = int'(op); m_r0 = m_ring; m_src = data; m_dir = dir_eff;
                m_n = int'(cnt); m_t = 0;
                if (m_n == 0) m_done = 1; else m_active = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ring",  ring,  m_ring);
            chk("ready", ready, !m_active && !m_done);
            chk("busy",  busy,  m_active || m_done);
            chk("done",  done,  m_done);
        end
    end

    // Present a command for one accept edge; returns in the first cycle after accept
    // with the command fields scrambled to show they are not re-sampled.
    task automatic send(input logic [1:0] o, input logic [7:0] d, input logic [3:0] c);
        @(negedge clk);
        valid = 1'b1; op = o; data = d; cnt = c;
        @(negedge clk);
        valid = 1'b0; op = 2'($urandom); data = 8'($urandom); cnt = 4'($urandom); dir = 1'b0;
    endtask

    // Cycle index (1 = first cycle after accept) at which done_o is seen, bounded.
    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic load(input logic [7:0] v);
        send(2'd1, v, 4'd0);
        @(negedge clk);
    endtask

    int c;

    initial begin
        rst = 1'b1; valid = 1'b0; op = '0; data = '0; cnt = '0; abort = 1'b0; dir = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ring", ring, 8'hAA);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // LOAD
        send(2'd1, 8'h01, 4'd0);
        chk("load_ring", ring, 8'h01);
        chk("load_done", done, 1'b1);
        chk("load_ready", ready, 1'b0);
        @(negedge clk);
        chk("load_done_end", done, 1'b0);
        chk("load_ready_end", ready, 1'b1);

        // ROTATE 3 from 01
        send(2'd2, 8'hFF, 4'd3);
        wait_done(c);
        chk("rot3_cycle", c, 4);
        chk("rot3_ring", ring, 8'h08);
        @(negedge clk);

        // ROTATE 8 returns original
        load(8'h01);
        send(2'd2, 8'h00, 4'd8);
        wait_done(c);
        chk("rot8_cycle", c, 9);
        chk("rot8_ring", ring, 8'h01);
        @(negedge clk);

        // ROTATE 0
        send(2'd2, 8'h00, 4'd0);
        chk("rot0_done", done, 1'b1);
        chk("rot0_ring", ring, 8'h01);
        @(negedge clk);

        // SHIFT_IN 05 x4 from 00
        load(8'h00);
        send(2'd3, 8'h05, 4'd4);
        wait_done(c);
        chk("shin_cycle", c, 5);
        chk("shin_ring", ring, 8'h0A);
        @(negedge clk);

        // Abort ROTATE 5 from 81 after 2 steps
        load(8'h81);
        send(2'd2, 8'h00, 4'd5);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre", ring, 8'h06);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ring", ring, 8'h06);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        send(2'd1, 8'h3C, 4'd0);
        chk("post_abort_load", ring, 8'h3C);
        @(negedge clk);

        // Async reset in the middle of a shift
        load(8'h01);
        send(2'd2, 8'h00, 4'd12);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ring", ring, 8'hAA);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RING_SHIFT_CTRL_DIR_EN
        load(8'h01);
        @(negedge clk);
        valid = 1'b1; op = 2'd2; data = 8'h00; cnt = 4'd1; dir = 1'b1;
        @(negedge clk);
        valid = 1'b0; dir = 1'b0;
        wait_done(c);
        chk("right_cycle", c, 2);
        chk("right_ring", ring, 8'h80);
        @(negedge clk);
`endif

        // Randomized commands and aborts
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 2) != 0);
            op    = 2'($urandom);
            data  = 8'($urandom);
            cnt   = 4'($urandom);
            abort = ($urandom_range(0, 9) == 0);
            dir   = 1'($urandom);
        end
        @(negedge clk);
        valid = 1'b0; abort = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_shift_ctrl.md
Name: ring_shift_ctrl

Overview:
- Command-driven sequencer for an SR_W-bit ring shift register.
- Owns the ring flops (bit i fed from bit (i-1) mod SR_W) and an FSM that loads, rotates or serially shifts-in under a valid/ready command handshake.
- Used as the stimulus/control engine for ff-chain datapaths in unit testbenches and simulation models.

Parameters:
- SR_W, 8, ring width in bits (>= 2).
- CNT_W, 4, width of step count field.
- RESET_PATTERN, 8'hAA, ring value after reset (bit i = i % 2 for the default); width SR_W.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  controller can accept a command.
- cmd_op_i  input  2  opcode: 0 = NOP, 1 = LOAD, 2 = ROTATE, 3 = SHIFT_IN.
- cmd_data_i  input  SR_W  LOAD value / SHIFT_IN serial source.
- cmd_cnt_i  input  CNT_W  number of steps for ROTATE / SHIFT_IN.
- abort_i  input  1  terminate an active shift sequence.
- ring_o  output  SR_W  current ring contents.
- busy_o  output  1  FSM not in IDLE.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): ring_o = RESET_PATTERN, FSM = IDLE, cmd_ready_o = 1, busy_o = 0, done_o = 0, step counter = 0.
- States: IDLE, SHIFT, DONE.
  - cmd_ready_o = 1 only in IDLE.
  - busy_o = 1 in SHIFT and DONE.
  - done_o = 1 only in DONE.
- Accept = cmd_valid_i & cmd_ready_o at a rising edge. Command fields are sampled only at accept; later changes are ignored.
- NOP: accepted, no state change, no done_o.
- LOAD: at the accept edge, ring <= cmd_data_i and FSM -> DONE. done_o is high the following cycle.
- ROTATE, n = cmd_cnt_i:
  - n = 0: FSM -> DONE, ring unchanged.
  - Otherwise FSM -> SHIFT with remaining = n.
  - Each SHIFT cycle: ring <= {ring[SR_W-2:0], ring[SR_W-1]}, remaining decrements.
  - Leave SHIFT for DONE on the edge that performs the last step.
  - Exactly n shifts; done_o is high in cycle n+1 after accept.
- SHIFT_IN, n = cmd_cnt_i:
  - Same sequencing as ROTATE, but ring <= {ring[SR_W-2:0], b_k}.
  - b_k = latched cmd_data_i[k] for step k = 0..n-1; b_k = 0 for k >= SR_W.
- n >= SR_W is legal. ROTATE by SR_W returns the original value.
- DONE always lasts exactly one cycle, then IDLE. No back-to-back accept is possible in the DONE cycle.
- abort_i in SHIFT: FSM -> IDLE at the next edge. The step on that edge is not performed, the ring holds its partial value, and done_o is not asserted. abort_i is ignored in IDLE and DONE.
- Invalid op encodings cannot occur (2-bit full decode).

Optional Feature:
- Macro: RING_SHIFT_CTRL_DIR_EN.
- Defined:
  - Adds port cmd_dir_i (input, 1 bit), latched at accept.
  - cmd_dir_i = 1 selects right direction: ROTATE uses ring <= {ring[0], ring[SR_W-1:1]}; SHIFT_IN inserts b_k at bit SR_W-1.
  - cmd_dir_i = 0 behaves as the base block.
- Undefined: port absent; direction is always left as above.

Test Plan:
- Reset, SR_W = 8 -> ring_o = 8'hAA, cmd_ready_o = 1, busy_o = 0, done_o = 0. Assert reset_i mid-SHIFT -> immediately 8'hAA, IDLE.
- LOAD 8'h01 -> ring_o = 8'h01 after the accept edge; done_o high exactly one cycle, next cycle; cmd_ready_o low during that cycle.
- ROTATE from 8'h01:
  - cnt = 3 -> 8'h08, done_o in 4th cycle after accept.
  - cnt = 8 -> 8'h01.
  - cnt = 0 -> 8'h01, done_o in 1st cycle.
- SHIFT_IN data 8'h05, cnt = 4, from 8'h00 -> 8'h0A. Changing cmd_data_i after accept has no effect.
- ROTATE cnt = 5 from 8'h81, abort_i asserted after 2 steps -> ring_o = 8'h06, IDLE, no done_o pulse, next command accepted.
- With RING_SHIFT_CTRL_DIR_EN defined: ROTATE right, cnt = 1, from 8'h01 -> 8'h80.
